// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, instruction field layout
// and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_DATA_W = 8;
    localparam int CPU_OPC_W  = 3;

    // Instruction layout: opcode in the top bits, operand in the low ADDR_W bits.
    localparam int OPC_MSB = CPU_DATA_W - 1;
    localparam int OPC_LSB = CPU_DATA_W - CPU_OPC_W;
    localparam int OPD_MSB = CPU_ADDR_W - 1;

    localparam logic [CPU_OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [CPU_OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [CPU_OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [CPU_OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [CPU_OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [CPU_OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [CPU_OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [CPU_OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus between the fetch sequencer (master) and instruction memory / controller (slave).
interface instr_fetch_seq_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int OPC_W  = CPU_OPC_W
) ();

    // Memory handshake: mem_rd is the request and stays high with mem_addr stable
    // until the cycle mem_ack is high; mem_rdata is taken in that same cycle.
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic              instr_valid;
    logic              ctrl_done;
    logic              skip;
    logic              branch;
    logic              acc_zero;
    logic              resume;
    logic              halted;

    modport master (
        output mem_rd, mem_addr, opcode, operand, instr_valid, halted,
        input  mem_ack, mem_rdata, ctrl_done, skip, branch, acc_zero, resume
    );

    modport slave (
        input  mem_rd, mem_addr, opcode, operand, instr_valid, halted,
        output mem_ack, mem_rdata, ctrl_done, skip, branch, acc_zero, resume
    );

endinterface

// File: rtl/instr_fetch_seq_pc_next.sv
// Next-PC selection: branch target, skip (PC+2) or sequential (PC+1), wrapping modulo 2^ADDR_W.
module pc_next #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] operand,
    input  logic              branch,
    input  logic              skip_taken,
    output logic [ADDR_W-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc + ADDR_W'(1);
        if (branch) begin
            pc_nxt = operand;
        end else if (skip_taken) begin
            pc_nxt = pc + ADDR_W'(2);
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencing front end: owns PC and IR, fetches from instruction memory,
// hands opcode/operand to the controller and halts on HLT.
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter int                OPC_W    = CPU_OPC_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_fetch_seq_if.master        bus,
    output state_t                   dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_nxt;
    logic              in_exec;

    // Outside EXEC the mux degenerates to PC+1, which is what HLT needs in DECODE.
    assign in_exec = (state_q == ST_EXEC);

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc         (pc_q),
        .operand    (bus.operand),
        .branch     (in_exec & bus.branch),
        .skip_taken (in_exec & bus.skip & bus.acc_zero),
        .pc_nxt     (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: begin
                if (bus.mem_ack) begin
                    ir_d    = bus.mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.opcode == OPC_W'(OP_HLT)) begin
                    pc_d    = pc_nxt;
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.ctrl_done) begin
                    pc_d    = pc_nxt;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // The request is a pure decode of WAIT_MEM, so it is low in reset and drops right after the ack.
    assign bus.mem_rd      = (state_q == ST_WAIT_MEM);
    assign bus.mem_addr    = pc_q;
    assign bus.opcode      = ir_q[DATA_W-1 -: OPC_W];
    assign bus.operand     = ir_q[ADDR_W-1:0];
    assign bus.instr_valid = (state_q == ST_DECODE);
    assign bus.halted      = (state_q == ST_HALTED);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: memory/controller driver tasks and a
// scoreboard of expected fetch addresses.
module tb_instr_fetch_seq;
    import cpu_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    instr_fetch_seq_if bus ();

    instr_fetch_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pass_cnt = 0;
    int         total = 0;
    logic [4:0] exp_q[$];
    logic [4:0] model_pc = '0;
    logic [4:0] last_operand = '0;
    int         last_rd_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_rd(output bit ok);
        int n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.mem_rd === 1'b1);
        if (!ok) begin
            total++;
            $error("FAIL fetch_timeout: got no mem_rd after %0d cycles, expected a request", n);
        end
    endtask

    task automatic pop_addr();
        logic [4:0] ea;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL sb_empty: got fetch at %0h, expected no fetch", bus.mem_addr);
            return;
        end
        ea = exp_q.pop_front();
        chk("fetch_addr", bus.mem_addr, ea);
        model_pc = ea;
    endtask

    task automatic fetch_instr(input logic [7:0] data, input int delay, input bit chk_gap);
        bit ok;
        wait_rd(ok);
        if (!ok) return;
        pop_addr();
        if (chk_gap) chk("cycles_per_instr", cyc - last_rd_cyc, 4);
        last_rd_cyc = cyc;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("rd_held", bus.mem_rd, 1);
            chk("addr_stable", bus.mem_addr, model_pc);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        last_operand  = data[4:0];
        chk("instr_valid", bus.instr_valid, 1);
        chk("opcode", bus.opcode, data[7:5]);
        chk("operand", bus.operand, data[4:0]);
        chk("rd_dropped", bus.mem_rd, 0);
    endtask

    task automatic exec_instr(input logic br, input logic sk, input logic az, input int delay);
        logic [4:0] nxt;
        @(negedge clk);
        chk("valid_pulse", bus.instr_valid, 0);
        chk("in_exec", dbg_state, ST_EXEC);
        // Noise on the flags and resume while ctrl_done is low must have no effect.
        for (int i = 0; i < delay; i++) begin
            bus.branch = 1'b1; bus.skip = 1'b1; bus.acc_zero = 1'b1; bus.resume = 1'b1;
            @(negedge clk);
            chk("exec_wait", dbg_state, ST_EXEC);
        end
        if (br)             nxt = last_operand;
        else if (sk && az)  nxt = model_pc + 5'd2;
        else                nxt = model_pc + 5'd1;
        exp_q.push_back(nxt);
        bus.ctrl_done = 1'b1; bus.branch = br; bus.skip = sk; bus.acc_zero = az; bus.resume = 1'b0;
        @(negedge clk);
        bus.ctrl_done = 1'b0; bus.branch = 1'b0; bus.skip = 1'b0; bus.acc_zero = 1'b0;
        chk("back_to_fetch", dbg_state, ST_FETCH);
    endtask

    initial begin
        bit ok;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ctrl_done = 1'b0;
        bus.skip = 1'b0; bus.branch = 1'b0; bus.acc_zero = 1'b0; bus.resume = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_pc", bus.mem_addr, 0);
        chk("rst_state", dbg_state, ST_FETCH);
        rst_n = 1'b1;
        exp_q.push_back(5'd0);

        // Get to PC=5, then reset in the middle of WAIT_MEM
        fetch_instr(8'b111_00101, 0, 0);
        exec_instr(1, 0, 0, 0);
        wait_rd(ok);
        if (ok) pop_addr();
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_rd", bus.mem_rd, 0);
        chk("midrst_pc", bus.mem_addr, 0);
        chk("midrst_state", dbg_state, ST_FETCH);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("late_ack_ignored", dbg_state, ST_WAIT_MEM);
        chk("late_ack_valid", bus.instr_valid, 0);
        exp_q.push_back(5'd0);

        // ADD at 0, sequential, 4 cycles per instruction
        fetch_instr(8'b010_00111, 0, 0);
        exec_instr(0, 0, 0, 0);
        fetch_instr(8'b111_00011, 0, 1);
        exec_instr(1, 0, 0, 0);

        // SKZ at 3 taken, then not taken
        fetch_instr(8'b001_00000, 0, 0);
        exec_instr(0, 1, 1, 0);
        fetch_instr(8'b111_00011, 0, 0);
        exec_instr(1, 0, 0, 0);
        fetch_instr(8'b001_00000, 0, 0);
        exec_instr(0, 1, 0, 1);
        fetch_instr(8'b111_00010, 0, 0);
        exec_instr(1, 0, 0, 0);

        // JMP 20 at 2 with skip and acc_zero also set
        fetch_instr(8'b111_10100, 0, 0);
        exec_instr(1, 1, 1, 0);
        fetch_instr(8'b111_11111, 0, 0);
        exec_instr(1, 0, 0, 0);

        // Wrap: skip at 31, then sequential at 31
        fetch_instr(8'b001_00000, 0, 0);
        exec_instr(0, 1, 1, 0);
        fetch_instr(8'b111_11111, 0, 0);
        exec_instr(1, 0, 0, 0);
        fetch_instr(8'b010_00001, 0, 0);
        exec_instr(0, 0, 0, 0);
        fetch_instr(8'b111_01001, 0, 0);
        exec_instr(1, 0, 0, 0);

        // HLT at 9: stays halted, ignores ctrl_done, resumes at 10
        fetch_instr(8'b000_00000, 0, 0);
        @(negedge clk);
        chk("halted", bus.halted, 1);
        chk("halt_state", dbg_state, ST_HALTED);
        bus.ctrl_done = 1'b1; bus.branch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_no_rd", bus.mem_rd, 0);
            chk("halt_held", bus.halted, 1);
        end
        bus.ctrl_done = 1'b0; bus.branch = 1'b0;
        bus.resume = 1'b1;
        exp_q.push_back(model_pc + 5'd1);
        @(negedge clk);
        bus.resume = 1'b0;
        chk("resume_halted", bus.halted, 0);
        chk("resume_state", dbg_state, ST_FETCH);

        // Slow memory at 10, then a late ctrl_done
        fetch_instr(8'b010_00100, 3, 0);
        exec_instr(0, 0, 0, 2);
        wait_rd(ok);
        if (ok) pop_addr();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
